// File: rtl/uart_fifo_model.sv
// uart_fifo_model: UART transmitter and receiver, each buffered by a FIFO.
// Latency: TX write to start bit on txd = 2 clocks; RX push at the stop-bit mid-sample.
// Backpressure: tx_ready low while the TX FIFO is full; a full RX FIFO drops the frame and pulses rx_overflow.
//
// Ports:
//   clk, rst           sole clock, synchronous active-high reset
//   rxd / txd          serial in (asynchronous, synchronised here) / serial out (registered, idle high)
//   tx_valid/tx_data/tx_ready                         TX FIFO write side
//   rx_valid/rx_data/rx_frame_err/rx_parity_err/rx_ready  RX FIFO head and pop
//   rx_overflow        one-clock pulse per dropped received frame
//   tx_busy            TX FIFO non-empty or a frame still on the line
// Optional: define UART_MODEL_LOG_EN to print a line per TX pop, RX push and RX error.

// Small synchronous FIFO; the extra pointer bit separates full from empty.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module uart_fifo_model_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module uart_fifo_model #(
  parameter int CLK_FREQ  = 90_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overflow,
  output logic                 tx_busy
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- TX ----------------
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_line_bit;
  logic                 tx_on_line;

  uart_fifo_model_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign tx_ready = !tx_full;
  // Popping at the end of STOP chains frames with no idle bit between them.
  assign tx_pop   = !tx_empty &&
                    (tx_state == S_IDLE || (tx_state == S_STOP && tx_cnt == CNT_LAST));
  // tx_on_line covers the final clock of the stop bit, which txd shows one clock late.
  assign tx_busy  = !tx_empty || (tx_state != S_IDLE) || tx_on_line;

  always_comb begin
    tx_line_bit = 1'b1;
    case (tx_state)
      S_START:  tx_line_bit = 1'b0;
      S_DATA:   tx_line_bit = tx_shift[0];
      S_PARITY: tx_line_bit = tx_par;
      default:  tx_line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      txd        <= 1'b1;
      tx_on_line <= 1'b0;
    end else begin
      // txd lags the state by one clock, so every bit still lasts DIV clocks.
      txd        <= tx_line_bit;
      tx_on_line <= (tx_state != S_IDLE);
      if (tx_pop) begin
        tx_state <= S_START;
        tx_cnt   <= '0;
        tx_shift <= tx_head;
        tx_par   <= par_of(tx_head);
      end else begin
        case (tx_state)
          S_IDLE: ;
          S_START: begin
            if (tx_cnt == CNT_LAST) begin
              tx_state <= S_DATA;
              tx_cnt   <= '0;
              tx_bit   <= '0;
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          S_DATA: begin
            if (tx_cnt == CNT_LAST) begin
              tx_cnt   <= '0;
              tx_shift <= tx_shift >> 1;
              if (tx_bit == BIT_LAST) tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
              else                    tx_bit   <= tx_bit + 3'd1;
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          S_PARITY: begin
            if (tx_cnt == CNT_LAST) begin
              tx_state <= S_STOP;
              tx_cnt   <= '0;
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          S_STOP: begin
            if (tx_cnt == CNT_LAST) begin
              tx_state <= S_IDLE;
              tx_cnt   <= '0;
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic [DATA_BITS+1:0] rx_head;

  assign rx_push = (rx_state == S_STOP) && (rx_cnt == CNT_LAST);
  assign rx_pop  = rx_valid && rx_ready;

  uart_fifo_model_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data ({rx_shift, ~rx_s2, rx_perr}),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_head[DATA_BITS+1:2];
  assign rx_frame_err  = rx_valid && rx_head[1];
  assign rx_parity_err = rx_valid && rx_head[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= S_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_perr     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_s1       <= rxd;
      rx_s2       <= rx_s1;
      rx_prev     <= rx_s2;
      rx_overflow <= rx_push && rx_full && !rx_pop;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
            rx_perr  <= 1'b0;
          end
        end
        S_START: begin
          // Mid start bit: a high line means the falling edge was a glitch.
          if (rx_cnt == CNT_HALF) begin
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_cnt   <= '0;
            rx_bit   <= '0;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        S_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        S_PARITY: begin
          if (rx_cnt == CNT_LAST) begin
            rx_perr  <= (rx_s2 != par_of(rx_shift));
            rx_state <= S_STOP;
            rx_cnt   <= '0;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        S_STOP: begin
          // The push itself is combinational on this same edge (rx_push).
          if (rx_cnt == CNT_LAST) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_MODEL_LOG_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (tx_pop) $display("[uart model] sending data: 0x%x", tx_head);
      if (rx_push) begin
        if (rx_full && !rx_pop) $display("[uart model] overflow, frame dropped: 0x%x", rx_shift);
        else                    $display("[uart model] received data: 0x%x", rx_shift);
        if (!rx_s2)  $display("[uart model] frame error: 0x%x", rx_shift);
        if (rx_perr) $display("[uart model] parity error: 0x%x", rx_shift);
      end
    end
  end
`else
  // Logging disabled: no display statements, identical cycle behaviour.
`endif
endmodule

// File: tb/tb_uart_fifo_model.sv
module tb_uart_fifo_model;
  localparam int DIV = 16;          // (160 + 5) / 10
  localparam int FRAME = DIV * 11;  // start + 8 data + parity + stop

  logic       clk = 1'b0;
  logic       rst;
  logic       loop_en, rxd_drv, rxd_odd;
  logic       m_rxd, m_txd, m_tx_valid, m_tx_ready, m_rx_valid, m_rx_ready;
  logic [7:0] m_tx_data, m_rx_data;
  logic       m_rx_frame_err, m_rx_parity_err, m_rx_overflow, m_tx_busy;
  logic       o_txd, o_tx_valid, o_tx_ready, o_rx_valid, o_rx_ready;
  logic [7:0] o_tx_data, o_rx_data;
  logic       o_rx_frame_err, o_rx_parity_err, o_rx_overflow, o_tx_busy;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb [$];   // main DUT: {data, frame_err, parity_err}
  logic [9:0] sbo [$];  // odd-parity DUT

  always #5 clk = ~clk;
  assign m_rxd = loop_en ? m_txd : rxd_drv;

  uart_fifo_model #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(2),
                    .TX_DEPTH(16), .RX_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .rxd(m_rxd), .txd(m_txd),
    .tx_valid(m_tx_valid), .tx_data(m_tx_data), .tx_ready(m_tx_ready),
    .rx_valid(m_rx_valid), .rx_data(m_rx_data), .rx_ready(m_rx_ready),
    .rx_frame_err(m_rx_frame_err), .rx_parity_err(m_rx_parity_err),
    .rx_overflow(m_rx_overflow), .tx_busy(m_tx_busy));

  uart_fifo_model #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(1),
                    .TX_DEPTH(16), .RX_DEPTH(4)) u_odd (
    .clk(clk), .rst(rst), .rxd(rxd_odd), .txd(o_txd),
    .tx_valid(o_tx_valid), .tx_data(o_tx_data), .tx_ready(o_tx_ready),
    .rx_valid(o_rx_valid), .rx_data(o_rx_data), .rx_ready(o_rx_ready),
    .rx_frame_err(o_rx_frame_err), .rx_parity_err(o_rx_parity_err),
    .rx_overflow(o_rx_overflow), .tx_busy(o_tx_busy));

  function automatic logic exp_par(input logic [7:0] d, input bit odd);
    return odd ? ~^d : ^d;
  endfunction

  task automatic drive_line(input bit odd, input logic v, input int n);
    if (odd) rxd_odd = v; else rxd_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit odd, input logic [7:0] d, input logic par_bit, input logic stop_b);
    drive_line(odd, 1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_line(odd, d[i], DIV);
    drive_line(odd, par_bit, DIV);
    drive_line(odd, stop_b, DIV);
    drive_line(odd, 1'b1, DIV);
  endtask

  task automatic wait_rx(input bit odd, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((odd ? o_rx_valid : m_rx_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pop_head(input bit odd);
    if (odd) o_rx_ready = 1'b1; else m_rx_ready = 1'b1;
    @(negedge clk);
    o_rx_ready = 1'b0;
    m_rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_txd, m_tx_ready, m_tx_busy, m_rx_valid} !== 4'b1100) begin
      errors++; $display("FAIL reset_tx: got txd/rdy/busy/rxv=%b expected 1100", {m_txd, m_tx_ready, m_tx_busy, m_rx_valid});
    end
    checks++;
    if ({m_rx_frame_err, m_rx_parity_err, m_rx_overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_rx_flags: got %b expected 000", {m_rx_frame_err, m_rx_parity_err, m_rx_overflow});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_txd, m_tx_ready, m_tx_busy, m_rx_valid, o_rx_valid} !== 5'b11000) begin
      errors++; $display("FAIL reset_release: got %b expected 11000", {m_txd, m_tx_ready, m_tx_busy, m_rx_valid, o_rx_valid});
    end
  endtask

  task automatic test_tx_frame;
    logic [7:0] d;
    logic       bits [11];
    int         bad;
    d = 8'hA5;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9]  = exp_par(d, 1'b0);
    bits[10] = 1'b1;
    loop_en = 1'b0;
    m_tx_valid = 1'b1; m_tx_data = d;
    @(negedge clk);
    m_tx_valid = 1'b0;
    checks++;
    if (m_txd !== 1'b1 || m_tx_busy !== 1'b1) begin
      errors++; $display("FAIL tx_write_plus1: got txd=%b busy=%b expected 1 1", m_txd, m_tx_busy);
    end
    @(negedge clk);
    checks++;
    if (m_txd !== 1'b1) begin errors++; $display("FAIL tx_write_plus2: got txd=%b expected 1", m_txd); end
    @(negedge clk);
    checks++;
    if (m_txd !== 1'b0) begin errors++; $display("FAIL tx_start_fall: got txd=%b expected 0", m_txd); end
    for (int k = 0; k < 11; k++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (m_txd !== bits[k]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL tx_bit%0d: %0d of %0d clocks wrong, expected level %b", k, bad, DIV, bits[k]);
      end
    end
    checks++;
    if (m_tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_in_stop: got %b expected 1", m_tx_busy); end
    @(negedge clk);
    checks++;
    if (m_tx_busy !== 1'b0 || m_txd !== 1'b1) begin
      errors++; $display("FAIL tx_after_stop: got busy=%b txd=%b expected 0 1", m_tx_busy, m_txd);
    end
  endtask

  task automatic test_glitch;
    bit ok;
    logic [9:0] e;
    loop_en = 1'b0;
    drive_line(1'b0, 1'b0, 4);
    drive_line(1'b0, 1'b1, 3 * DIV);
    checks++;
    if (m_rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_push: got rx_valid=%b expected 0", m_rx_valid); end
    sb.push_back({8'h96, 2'b00});
    send_frame(1'b0, 8'h96, exp_par(8'h96, 1'b0), 1'b1);
    wait_rx(1'b0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL glitch_recover: rx_valid=0 expected 1 (timeout)");
    end else begin
      e = sb.pop_front();
      if ({m_rx_data, m_rx_frame_err, m_rx_parity_err} !== e) begin
        errors++; $display("FAIL glitch_recover: got %h expected %h", {m_rx_data, m_rx_frame_err, m_rx_parity_err}, e);
      end
      pop_head(1'b0);
    end
  endtask

  task automatic test_frame_err;
    bit ok;
    logic [9:0] e;
    loop_en = 1'b0;
    sb.push_back({8'h3C, 1'b1, 1'b0});
    send_frame(1'b0, 8'h3C, exp_par(8'h3C, 1'b0), 1'b0);
    wait_rx(1'b0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL frame_err: rx_valid=0 expected 1 (timeout)");
    end else begin
      e = sb.pop_front();
      if ({m_rx_data, m_rx_frame_err, m_rx_parity_err} !== e) begin
        errors++; $display("FAIL frame_err: got data/ferr/perr %h expected %h", {m_rx_data, m_rx_frame_err, m_rx_parity_err}, e);
      end
      pop_head(1'b0);
    end
    checks++;
    if (m_rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_pop: got rx_valid=%b expected 0", m_rx_valid); end
  endtask

  task automatic test_parity_err;
    bit ok;
    logic [9:0] e;
    logic [7:0] d [2];
    logic       wrong [2];
    d[0] = 8'hA5; wrong[0] = 1'b1;
    d[1] = 8'h01; wrong[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sbo.push_back({d[i], 1'b0, wrong[i]});
      send_frame(1'b1, d[i], exp_par(d[i], 1'b1) ^ wrong[i], 1'b1);
      wait_rx(1'b1, 40, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL parity_%0d: rx_valid=0 expected 1 (timeout)", i);
      end else begin
        e = sbo.pop_front();
        if ({o_rx_data, o_rx_frame_err, o_rx_parity_err} !== e) begin
          errors++; $display("FAIL parity_%0d: got %h expected %h", i, {o_rx_data, o_rx_frame_err, o_rx_parity_err}, e);
        end
        pop_head(1'b1);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, first_low, busy_end, got, wr_idx;
    logic [7:0] wd;
    logic [9:0] e;
    cyc = 0; first_low = -1; busy_end = -1; got = 0; wr_idx = 0;
    loop_en = 1'b1;
    m_rx_ready = 1'b0;
    while (cyc < 4000 && (got < 17 || busy_end < 0)) begin
      @(negedge clk);
      cyc++;
      if (first_low < 0 && m_txd === 1'b0) first_low = cyc;
      if (first_low >= 0 && busy_end < 0 && m_tx_busy === 1'b0) busy_end = cyc;
      if (m_rx_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got unexpected rx_data %h", m_rx_data);
        end else begin
          e = sb.pop_front();
          if ({m_rx_data, m_rx_frame_err, m_rx_parity_err} !== e) begin
            errors++; $display("FAIL b2b_data%0d: got %h expected %h", got, {m_rx_data, m_rx_frame_err, m_rx_parity_err}, e);
          end
        end
        got++;
        m_rx_ready = 1'b1;
      end else begin
        m_rx_ready = 1'b0;
      end
      if (wr_idx == 17) begin
        checks++;
        if (m_tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got tx_ready=%b expected 0", m_tx_ready); end
        m_tx_valid = 1'b1; m_tx_data = 8'hEE;  // must be ignored
        wr_idx = 18;
      end else if (wr_idx == 18) begin
        m_tx_valid = 1'b0;
        wr_idx = 19;
      end else if (wr_idx < 17) begin
        if (wr_idx == 16) begin
          checks++;
          if (m_tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_last_slot: got tx_ready=%b expected 1", m_tx_ready); end
        end
        wd = (wr_idx == 0) ? 8'hC3 : 8'(wr_idx - 1);
        m_tx_valid = 1'b1; m_tx_data = wd;
        sb.push_back({wd, 2'b00});
        wr_idx++;
      end
    end
    @(negedge clk);
    m_rx_ready = 1'b0;
    m_tx_valid = 1'b0;
    checks++;
    if (got != 17 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d frames (%0d left) expected 17", got, sb.size());
    end
    checks++;
    if (busy_end - first_low != 17 * FRAME) begin
      errors++; $display("FAIL b2b_gapless: got line time %0d expected %0d", busy_end - first_low, 17 * FRAME);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic [9:0] e;
    int held, exp_ovf, ovf_cycles, cyc;
    held = 0; exp_ovf = 0; ovf_cycles = 0; cyc = 0;
    loop_en = 1'b1;
    m_rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'(17 * (i + 1));
      m_tx_valid = 1'b1; m_tx_data = d;
      if (held < 4) begin sb.push_back({d, 2'b00}); held++; end
      else exp_ovf++;
      @(negedge clk);
      if (m_rx_overflow === 1'b1) ovf_cycles++;
    end
    m_tx_valid = 1'b0;
    while (cyc < 1200 && m_tx_busy === 1'b1) begin
      @(negedge clk);
      cyc++;
      if (m_rx_overflow === 1'b1) ovf_cycles++;
    end
    repeat (20) begin
      @(negedge clk);
      if (m_rx_overflow === 1'b1) ovf_cycles++;
    end
    checks++;
    if (m_tx_busy !== 1'b0) begin errors++; $display("FAIL ovf_tx_done: got tx_busy=%b expected 0 (timeout)", m_tx_busy); end
    checks++;
    if (ovf_cycles != exp_ovf) begin errors++; $display("FAIL ovf_pulse: got %0d high clocks expected %0d", ovf_cycles, exp_ovf); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL ovf_head%0d: scoreboard empty", j);
      end else begin
        e = sb.pop_front();
        if (m_rx_valid !== 1'b1 || {m_rx_data, m_rx_frame_err, m_rx_parity_err} !== e) begin
          errors++; $display("FAIL ovf_head%0d: got valid=%b %h expected 1 %h", j, m_rx_valid, {m_rx_data, m_rx_frame_err, m_rx_parity_err}, e);
        end
      end
      pop_head(1'b0);
    end
    checks++;
    if (m_rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got rx_valid=%b expected 0", m_rx_valid); end
  endtask

  task automatic test_reset_mid_frame;
    int lows, valids;
    lows = 0; valids = 0;
    loop_en = 1'b1;
    m_tx_valid = 1'b1; m_tx_data = 8'h5A;
    @(negedge clk);
    m_tx_data = 8'h77;
    @(negedge clk);
    m_tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (m_txd !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got txd=%b expected 0", m_txd); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b expected 1", m_txd); end
    checks++;
    if (m_tx_ready !== 1'b1 || m_tx_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_fifo: got ready=%b busy=%b expected 1 0", m_tx_ready, m_tx_busy);
    end
    rst = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (m_txd !== 1'b1) lows++;
      if (m_rx_valid !== 1'b0) valids++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL rstmid_no_resume: got %0d txd low clocks expected 0", lows); end
    checks++;
    if (valids != 0) begin errors++; $display("FAIL rstmid_rx_discard: got %0d rx_valid clocks expected 0", valids); end
  endtask

  initial begin
    rst = 1'b1; loop_en = 1'b0; rxd_drv = 1'b1; rxd_odd = 1'b1;
    m_tx_valid = 1'b0; m_tx_data = '0; m_rx_ready = 1'b0;
    o_tx_valid = 1'b0; o_tx_data = '0; o_rx_ready = 1'b0;
    test_reset();
    test_tx_frame();
    test_glitch();
    test_frame_err();
    test_parity_err();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_model.md
UART_FIFO_MODEL -- requirements
Module: uart_fifo_model

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 90_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries; legal values are powers of 2, >= 2.
REQ-006 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries; legal values are powers of 2, >= 2.
REQ-007 SHALL have clk  in  1  sole clock.
REQ-008 SHALL have rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have rxd  in  1  serial input, asynchronous.
REQ-010 SHALL have txd  out  1  serial output, idle high.
REQ-011 SHALL have tx_valid  in  1  and tx_data  in  DATA_BITS, meaning write request and write data.
REQ-012 SHALL have tx_ready  out  1  meaning TX FIFO not full.
REQ-013 SHALL have rx_valid  out  1  and rx_data  out  DATA_BITS, meaning RX FIFO head valid and head data.
REQ-014 SHALL have rx_ready  in  1  meaning consumer pops the head.
REQ-015 SHALL have rx_frame_err  out  1  and rx_parity_err  out  1, meaning error flags of the head entry, valid while rx_valid is high.
REQ-016 SHALL have rx_overflow  out  1  meaning a one-cycle pulse when a received frame is dropped.
REQ-017 SHALL have tx_busy  out  1  meaning TX FIFO non-empty or a frame is on the line.

Function
REQ-018 SHALL use bit period DIV = (CLK_FREQ + BAUD/2) / BAUD clocks, computed at elaboration.
REQ-019 SHALL push tx_data into the TX FIFO on any edge where tx_valid and tx_ready are both high; a write while tx_ready is low SHALL be ignored.
REQ-020 SHALL implement a TX FSM with states IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE, each state lasting exactly DIV clocks.
REQ-021 SHALL pop the TX FIFO on leaving IDLE; txd SHALL fall 2 clocks after a write to an empty FIFO with the FSM idle.
REQ-022 SHALL send data bits LSB first, then the parity bit, then one stop bit (high).
REQ-023 SHALL start back-to-back frames with no idle gap when the FIFO is non-empty at the end of STOP.
REQ-024 SHALL register txd (no combinational path to txd).
REQ-025 SHALL pass rxd through a 2-flop synchroniser before use.
REQ-026 SHALL implement an RX FSM with states IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP.
REQ-027 SHALL enter START from IDLE on a synchronised falling edge, then re-sample at DIV/2; if the line is high, the event is a glitch and the FSM SHALL return to IDLE without a push.
REQ-028 SHALL sample each subsequent bit every DIV clocks, at mid-bit.
REQ-029 SHALL set the frame error when the stop sample is 0, and SHALL set the parity error when the parity sample mismatches.
REQ-030 SHALL push {data, frame_err, parity_err} at the stop sample, then return to IDLE.
REQ-031 SHALL pop the RX head on any edge where rx_valid and rx_ready are both high.
REQ-032 SHALL drop the frame and pulse rx_overflow for 1 clock when the RX FIFO is full at push time and no pop occurs that cycle.
REQ-033 SHALL accept the push without overflow when the FIFO is full and a pop occurs in the same cycle.
REQ-034 SHALL wrap FIFO pointers modulo depth, using an extra pointer bit to distinguish full from empty.

Reset
REQ-035 SHALL drive the following on the edge where rst is high: txd=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overflow=0, both FIFOs empty, both FSMs IDLE.
REQ-036 SHALL abandon any frame in progress on reset mid-frame: txd high next clock, partial RX data discarded and never pushed.

Configuration
REQ-037 SHALL, when macro UART_MODEL_LOG_EN is defined, print "[uart model] sending data: 0x%x" on each TX pop.
REQ-038 SHALL, when macro UART_MODEL_LOG_EN is defined, print "[uart model] received data: 0x%x" on each RX push, plus one line per frame error, parity error or overflow.
REQ-039 SHALL, when macro UART_MODEL_LOG_EN is undefined, contain no display statements, with cycle behaviour otherwise identical.

Verification
REQ-040 SHALL cover: CLK_FREQ=160, BAUD=10, PARITY=2, write 0xA5 -> txd low 2 clks later, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each 16 clks; tx_busy falls after the stop bit.
REQ-041 SHALL cover: txd looped to rxd, burst of 16 writes 0x00..0x0F with TX_DEPTH=16 -> tx_ready low after 16th write; rx_data pops 0x00..0x0F in order with no inter-frame gap on txd.
REQ-042 SHALL cover: RX_DEPTH=4, rx_ready=0, 5 frames received -> 5th dropped, rx_overflow pulses once, head remains the 1st frame.
REQ-043 SHALL cover: inject frame 0x3C with stop bit 0 -> rx_data=0x3C, rx_frame_err=1; odd-parity frame with wrong parity -> rx_parity_err=1.
REQ-044 SHALL cover: 4-clk low pulse on rxd -> no push; rst asserted mid-TX-frame -> txd=1 next clock, tx_ready=1, FIFO empty.
